register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural integer register file for the non-pipelined RV32I core: 32 registers × 32 bits.
- Two combinational read ports (rs1/rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- Sits between instruction decode (addresses) and ALU/writeback (data).

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH (32).
- WRITE_BYPASS, 0, 1 = a read of the register being written this cycle returns write_data combinationally; 0 = returns the stored (old) value.

Ports:
- clk  input  1  system clock; writes on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- read_address_port_a  input  ADDR_WIDTH  read port A register index (rs1).
- read_address_port_b  input  ADDR_WIDTH  read port B register index (rs2).
- write_address  input  ADDR_WIDTH  write register index (rd).
- write_data  input  DATA_WIDTH  data to write.
- write_enable  input  1  write strobe, sampled on rising clk.
- read_data_port_a  output  DATA_WIDTH  contents of register read_address_port_a.
- read_data_port_b  output  DATA_WIDTH  contents of register read_address_port_b.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Storage is 2**ADDR_WIDTH words of DATA_WIDTH bits, implemented as flops (async clear required).
- Reset:
  - Asserting reset immediately clears every register to 0, without waiting for a clock edge.
  - While reset is high, writes are ignored and both read outputs are 0.
- Write:
  - On rising clk with reset low, write_enable=1 and write_address≠0: reg[write_address] ← write_data.
  - The new value is visible on the read ports after the edge.
  - With write_enable=0, nothing changes.
- Register 0:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, regardless of bypass.
- Read:
  - Purely combinational, zero-cycle latency.
  - read_data_port_x = reg[read_address_port_x].
  - Ports A and B are independent and may address the same register.
- Read-during-write (same address, write_enable=1, address≠0):
  - WRITE_BYPASS=0: the read returns the old value until the edge.
  - WRITE_BYPASS=1: the read returns write_data combinationally.
- Reset mid-operation:
  - A write coincident with reset assertion is lost.
  - The first write honoured is at the first rising edge after reset deasserts.
- No X propagation: every register has a defined value from reset onward.
- No handshake and no stall; the write completes in one cycle.

Decomposition:
- Shared package (riscv_pkg), holding:
  - XLEN=32
  - REG_ADDR_W=5
  - NUM_REGS=32
  - ZERO_REG=5'd0
  - a typedef for the register word
- Parameter defaults are taken from these constants.
- No sub-module; a single flat module with a storage array, a write always-block and two read-mux assigns.

Test Plan:
1. Hold reset=1, set read_address_port_a=1, read_address_port_b=2 -> both outputs 0; write_enable=1 with write_address=15, write_data=0x0000000C -> reg 15 still reads 0.
2. Release reset; write 0x0000000C to reg 15 on one edge, then read port B at address 15 -> 0x0000000C after the edge; before the edge it returns 0 (WRITE_BYPASS=0) or 0x0000000C (WRITE_BYPASS=1).
3. Write 0xDEADBEEF to address 0 -> both ports reading address 0 return 0x00000000.
4. Write regs 1..31 with value 0x100+i, then read all pairs (i, 31-i) on ports A/B -> each returns its own written value; both ports reading the same address return identical data.
5. With write_enable=0, write_address=5, write_data=0xFFFFFFFF, clock several edges -> reg 5 is unchanged.
6. After populating registers, assert reset between clock edges -> all outputs drop to 0 immediately; after deassert, reading any address returns 0 until rewritten.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core constants and types.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [XLEN-1:0] reg_word_t;

endpackage

// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, optional write-to-read bypass.
module register_file
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = XLEN,
    parameter int unsigned ADDR_WIDTH   = REG_ADDR_W,
    parameter int          WRITE_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_address_port_a,
    input  logic [ADDR_WIDTH-1:0] read_address_port_b,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data_port_a,
    output logic [DATA_WIDTH-1:0] read_data_port_b
);

    localparam int unsigned     DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam bit              BYPASS_ON = (WRITE_BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  write_active;
    logic                  bypass_a;
    logic                  bypass_b;

    assign write_active = write_enable && (write_address != ZERO_ADDR);

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (write_active) begin
            regs[write_address] <= write_data;
        end
    end

    // Bypass is suppressed during reset so both ports read zero.
    assign bypass_a = BYPASS_ON && !reset && write_active &&
                      (write_address == read_address_port_a);
    assign bypass_b = BYPASS_ON && !reset && write_active &&
                      (write_address == read_address_port_b);

    assign read_data_port_a = (read_address_port_a == ZERO_ADDR) ? '0 :
                              bypass_a ? write_data : regs[read_address_port_a];
    assign read_data_port_b = (read_address_port_b == ZERO_ADDR) ? '0 :
                              bypass_b ? write_data : regs[read_address_port_b];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file, covering both bypass settings in parallel.
module tb_register_file;
    import riscv_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [REG_ADDR_W-1:0] ra, rb, wa;
    reg_word_t             wd;
    logic                  we;
    reg_word_t             a_nb, b_nb, a_by, b_by;

    reg_word_t mdl [NUM_REGS];
    reg_word_t exp_q [$];
    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    register_file #(.WRITE_BYPASS(0)) dut_nobyp (
        .clk(clk), .reset(reset),
        .read_address_port_a(ra), .read_address_port_b(rb),
        .write_address(wa), .write_data(wd), .write_enable(we),
        .read_data_port_a(a_nb), .read_data_port_b(b_nb)
    );

    register_file #(.WRITE_BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset),
        .read_address_port_a(ra), .read_address_port_b(rb),
        .write_address(wa), .write_data(wd), .write_enable(we),
        .read_data_port_a(a_by), .read_data_port_b(b_by)
    );

    task automatic check_equal(input string tag, input reg_word_t obs, input reg_word_t expv);
        assertions++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    function automatic reg_word_t model_read(input logic [REG_ADDR_W-1:0] addr, input bit byp);
        if (reset || addr == ZERO_REG) return '0;
        if (byp && we && wa == addr) return wd;
        return mdl[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(NUM_REGS); i++) mdl[i] = '0;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        clear_model();
    endtask

    // One rising edge; the model commits the write, then we return at the falling edge.
    task automatic clock_edge();
        @(posedge clk);
        if (!reset && we && wa != ZERO_REG) mdl[wa] = wd;
        @(negedge clk);
    endtask

    task automatic check_reads(input string tag, input logic [REG_ADDR_W-1:0] a,
                               input logic [REG_ADDR_W-1:0] b);
        ra = a;
        rb = b;
        #1;
        exp_q.push_back(model_read(a, 1'b0));
        exp_q.push_back(model_read(b, 1'b0));
        exp_q.push_back(model_read(a, 1'b1));
        exp_q.push_back(model_read(b, 1'b1));
        check_equal({tag, "/nb_a"}, a_nb, exp_q.pop_front());
        check_equal({tag, "/nb_b"}, b_nb, exp_q.pop_front());
        check_equal({tag, "/by_a"}, a_by, exp_q.pop_front());
        check_equal({tag, "/by_b"}, b_by, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
        assert_reset();
        @(negedge clk);

        check_reads("rst_read", 5'd1, 5'd2);
        we = 1'b1; wa = 5'd15; wd = 32'h0000_000C;
        check_reads("rst_wr_pre", 5'd15, 5'd15);
        clock_edge();
        check_reads("rst_wr_post", 5'd15, 5'd15);

        we = 1'b0;
        reset = 1'b0;
        check_reads("rel", 5'd15, 5'd1);

        we = 1'b1; wa = 5'd15; wd = 32'h0000_000C;
        check_reads("byp_pre", 5'd0, 5'd15);
        clock_edge();
        we = 1'b0;
        check_reads("wr_post", 5'd3, 5'd15);

        we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF;
        check_reads("x0_pre", 5'd0, 5'd0);
        clock_edge();
        we = 1'b0;
        check_reads("x0_post", 5'd0, 5'd0);

        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'h100 + 32'(i);
            clock_edge();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_reads($sformatf("pair%0d", i), 5'(i), 5'(31 - i));
            check_reads($sformatf("same%0d", i), 5'(i), 5'(i));
        end

        we = 1'b0; wa = 5'd5; wd = 32'hFFFF_FFFF;
        check_reads("we0_pre", 5'd5, 5'd5);
        repeat (3) clock_edge();
        check_reads("we0_post", 5'd5, 5'd6);

        #2;
        assert_reset();
        check_reads("async_rst", 5'd5, 5'd31);
        @(negedge clk);
        reset = 1'b0;
        check_reads("cleared_a", 5'd5, 5'd31);
        check_reads("cleared_b", 5'd15, 5'd1);

        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
        check_reads("first_wr_pre", 5'd7, 5'd8);
        clock_edge();
        we = 1'b0;
        check_reads("first_wr_post", 5'd7, 5'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
